// File: rtl/pc_ctrl.sv
// pc_ctrl: sequencing controller for the program counter and IF/ID register.
// Each cycle selects advance, redirect, hold (load-use) or freeze (memory
// stall), tracks IDLE/RUN/MEM_WAIT phases and keeps saturating debug counters.
// Ports:
//   clk_i, rst_i (async active-low)     clock and reset
//   start_i                             run enable, low forces IDLE
//   dmem_stall_i                        data memory busy, freeze pipeline
//   EX_memread_i, EX_rt_i               load in EX and its destination
//   ID_rs_i, ID_rt_i                    source fields of instruction in ID
//   branch_taken_i, branch_target_i     taken branch/jump resolved in ID
//   PC_plus4_i                          sequential next address
//   PC_next_o, PC_write_o, PC_stall_o   PC register controls
//   IFID_write_o, IFID_flush_o          IF/ID register controls
//   ID_bubble_o, pipe_freeze_o          bubble insert / global freeze
//   state_o                             00 IDLE, 01 RUN, 10 MEM_WAIT
//   stall_cnt_o, flush_cnt_o            saturating event counters
module pc_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             dmem_stall_i,
   input  logic             EX_memread_i,
   input  logic [4:0]       EX_rt_i,
   input  logic [4:0]       ID_rs_i,
   input  logic [4:0]       ID_rt_i,
   input  logic             branch_taken_i,
   input  logic [31:0]      branch_target_i,
   input  logic [31:0]      PC_plus4_i,
   output logic [31:0]      PC_next_o,
   output logic             PC_write_o,
   output logic             PC_stall_o,
   output logic             IFID_write_o,
   output logic             IFID_flush_o,
   output logic             ID_bubble_o,
   output logic             pipe_freeze_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_RUN      = 2'b01,
      ST_MEM_WAIT = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             hz;
   logic             active;

   // Load-use hazard: the load in EX writes a register the ID instruction reads.
   assign hz = EX_memread_i && (EX_rt_i != 5'd0) &&
               ((EX_rt_i == ID_rs_i) || (EX_rt_i == ID_rt_i));

   // The unused encoding behaves like IDLE.
   assign active = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

   // Next-state, counter and control decode; IDLE outputs are the defaults.
   always_comb begin
      state_d       = state_q;
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      PC_next_o     = PC_plus4_i;
      PC_write_o    = 1'b0;
      PC_stall_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IFID_flush_o  = 1'b1;
      ID_bubble_o   = 1'b1;
      pipe_freeze_o = 1'b0;

      if (!active || !start_i) begin
         state_d = (!active && start_i) ? ST_RUN : ST_IDLE;
      end else if (dmem_stall_i) begin
         // A pending branch is ignored here; ID is frozen and re-presents it.
         PC_stall_o    = 1'b1;
         pipe_freeze_o = 1'b1;
         IFID_flush_o  = 1'b0;
         ID_bubble_o   = 1'b0;
         state_d       = ST_MEM_WAIT;
         if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else if (hz) begin
         // Hazard beats a same-cycle branch; the branch retries next cycle.
         IFID_flush_o = 1'b0;
         state_d      = ST_RUN;
         if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else if (branch_taken_i) begin
         PC_write_o   = 1'b1;
         PC_next_o    = branch_target_i;
         IFID_write_o = 1'b1;
         ID_bubble_o  = 1'b0;
         state_d      = ST_RUN;
         if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
         PC_write_o   = 1'b1;
         IFID_write_o = 1'b1;
         IFID_flush_o = 1'b0;
         ID_bubble_o  = 1'b0;
         state_d      = ST_RUN;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign state_o     = state_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table, hand-written
// saturation/async-reset sequence, and randomized run against a reference model.
module tb_pc_ctrl;

   localparam int unsigned CW = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i, dmem_stall_i, EX_memread_i, branch_taken_i;
   logic [4:0]    EX_rt_i, ID_rs_i, ID_rt_i;
   logic [31:0]   branch_target_i, PC_plus4_i;
   logic [31:0]   PC_next_o;
   logic          PC_write_o, PC_stall_o, IFID_write_o, IFID_flush_o;
   logic          ID_bubble_o, pipe_freeze_o;
   logic [1:0]    state_o;
   logic [CW-1:0] stall_cnt_o, flush_cnt_o;

   int errors = 0;
   int checks = 0;

   pc_ctrl #(.CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dmem_stall_i(dmem_stall_i),
      .EX_memread_i(EX_memread_i), .EX_rt_i(EX_rt_i), .ID_rs_i(ID_rs_i), .ID_rt_i(ID_rt_i),
      .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
      .PC_plus4_i(PC_plus4_i), .PC_next_o(PC_next_o), .PC_write_o(PC_write_o),
      .PC_stall_o(PC_stall_o), .IFID_write_o(IFID_write_o), .IFID_flush_o(IFID_flush_o),
      .ID_bubble_o(ID_bubble_o), .pipe_freeze_o(pipe_freeze_o), .state_o(state_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        start, dmem, memrd;
      logic [4:0]  ex_rt, id_rs, id_rt;
      logic        br;
      logic [31:0] tgt, p4;
      logic [5:0]  ctl;   // {pc_write, pc_stall, ifid_write, ifid_flush, bubble, freeze}
      logic [31:0] nxt;
      logic [1:0]  st;
      logic [3:0]  sc, fc;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] ctl_now();
      return {PC_write_o, PC_stall_o, IFID_write_o, IFID_flush_o, ID_bubble_o, pipe_freeze_o};
   endfunction

   task automatic drive(input logic st, dm, mr, input logic [4:0] ert, irs, irt,
                        input logic br, input logic [31:0] tgt, p4);
      start_i = st; dmem_stall_i = dm; EX_memread_i = mr;
      EX_rt_i = ert; ID_rs_i = irs; ID_rt_i = irt;
      branch_taken_i = br; branch_target_i = tgt; PC_plus4_i = p4;
   endtask

   // Reference model: phase 0 idle, 1 run, 2 memory wait; counters as ints.
   typedef enum int {A_IDLE, A_FREEZE, A_HOLD, A_BRANCH, A_ADV} act_e;
   int m_phase, m_sc, m_fc;
   int cnt_max = (1 << CW) - 1;

   function automatic act_e m_action();
      bit hazard;
      hazard = EX_memread_i && EX_rt_i != 0 && (EX_rt_i == ID_rs_i || EX_rt_i == ID_rt_i);
      if (m_phase == 0 || !start_i) return A_IDLE;
      if (dmem_stall_i)             return A_FREEZE;
      if (hazard)                   return A_HOLD;
      if (branch_taken_i)           return A_BRANCH;
      return A_ADV;
   endfunction

   function automatic logic [5:0] m_ctl(input act_e a);
      case (a)
         A_FREEZE: return 6'b010001;
         A_HOLD:   return 6'b000010;
         A_BRANCH: return 6'b101100;
         A_ADV:    return 6'b101000;
         default:  return 6'b000110;
      endcase
   endfunction

   vec_t vecs[14];
   int   n_ph, n_sc, n_fc;
   act_e a;

   initial begin
      vecs[0]  = '{1,0,0,0,0,0,0,32'h0 ,32'd4 ,6'b000110,32'd4 ,2'd0,4'd0,4'd0};
      vecs[1]  = '{1,0,0,0,0,0,0,32'h0 ,32'd8 ,6'b101000,32'd8 ,2'd1,4'd0,4'd0};
      vecs[2]  = '{1,0,0,0,0,0,0,32'h0 ,32'd12,6'b101000,32'd12,2'd1,4'd0,4'd0};
      vecs[3]  = '{1,0,1,5,5,0,0,32'h0 ,32'd16,6'b000010,32'd16,2'd1,4'd0,4'd0};
      vecs[4]  = '{1,0,1,0,0,0,0,32'h0 ,32'd20,6'b101000,32'd20,2'd1,4'd1,4'd0};
      vecs[5]  = '{1,0,1,5,0,5,1,32'h40,32'd24,6'b000010,32'd24,2'd1,4'd1,4'd0};
      vecs[6]  = '{1,0,0,0,0,0,1,32'h40,32'd28,6'b101100,32'h40,2'd1,4'd2,4'd0};
      vecs[7]  = '{1,1,0,0,0,0,1,32'h80,32'd32,6'b010001,32'd32,2'd1,4'd2,4'd1};
      vecs[8]  = '{1,1,0,0,0,0,1,32'h80,32'd32,6'b010001,32'd32,2'd2,4'd3,4'd1};
      vecs[9]  = '{1,1,0,0,0,0,1,32'h80,32'd32,6'b010001,32'd32,2'd2,4'd4,4'd1};
      vecs[10] = '{1,0,0,0,0,0,1,32'h80,32'd32,6'b101100,32'h80,2'd2,4'd5,4'd1};
      vecs[11] = '{1,1,0,0,0,0,0,32'h0 ,32'd36,6'b010001,32'd36,2'd1,4'd5,4'd2};
      vecs[12] = '{0,1,0,0,0,0,0,32'h0 ,32'd40,6'b000110,32'd40,2'd2,4'd6,4'd2};
      vecs[13] = '{0,0,0,0,0,0,0,32'h0 ,32'd44,6'b000110,32'd44,2'd0,4'd6,4'd2};

      // Reset state with IDLE outputs.
      rst_i = 1'b0;
      drive(0,0,0,0,0,0,0,32'h0,32'h1234);
      #12;
      check("reset_state", 32'(state_o), 32'd0);
      check("reset_ctl", 32'(ctl_now()), 32'b000110);
      check("reset_next", PC_next_o, 32'h1234);
      check("reset_cnt", 32'({stall_cnt_o, flush_cnt_o}), 32'd0);
      @(posedge clk_i); #1 rst_i = 1'b1;

      // Directed table: each row is one cycle, checked before the closing edge.
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].start, vecs[i].dmem, vecs[i].memrd, vecs[i].ex_rt, vecs[i].id_rs,
               vecs[i].id_rt, vecs[i].br, vecs[i].tgt, vecs[i].p4);
         @(negedge clk_i);
         check($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
         check($sformatf("vec%0d_next", i), PC_next_o, vecs[i].nxt);
         check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].st));
         check($sformatf("vec%0d_cnt", i), 32'({stall_cnt_o, flush_cnt_o}),
               32'({vecs[i].sc, vecs[i].fc}));
         @(posedge clk_i); #1;
      end

      // Saturation: 20 hazard cycles from RUN with the counter starting at 6.
      drive(1,0,0,0,0,0,0,32'h0,32'd4);
      @(posedge clk_i); #1;
      for (int i = 0; i < 20; i++) begin
         drive(1,0,1,5'd7,5'd7,5'd1,0,32'h0,32'd8);
         @(posedge clk_i); #1;
      end
      check("sat_stall_cnt", 32'(stall_cnt_o), 32'd15);
      check("sat_state", 32'(state_o), 32'd1);
      check("sat_flush_cnt", 32'(flush_cnt_o), 32'd2);
      // Asynchronous reset mid-cycle clears everything without a clock edge.
      #2 rst_i = 1'b0;
      #1;
      check("async_rst_cnt", 32'(stall_cnt_o), 32'd0);
      check("async_rst_state", 32'(state_o), 32'd0);
      check("async_rst_ctl", 32'(ctl_now()), 32'b000110);
      @(posedge clk_i); #1 rst_i = 1'b1;

      // Randomized run against the reference model, with occasional reset pulses.
      m_phase = 0; m_sc = 0; m_fc = 0;
      n_ph = 0; n_sc = 0; n_fc = 0;
      for (int i = 0; i < 3000; i++) begin
         rst_i = ($urandom_range(0, 99) != 0);
         drive($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 2) == 0, $urandom, $urandom);
         if (!rst_i) begin
            m_phase = 0; m_sc = 0; m_fc = 0;
         end
         @(negedge clk_i);
         a = m_action();
         check("rnd_ctl", 32'(ctl_now()), 32'(m_ctl(a)));
         check("rnd_next", PC_next_o, (a == A_BRANCH) ? branch_target_i : PC_plus4_i);
         check("rnd_state", 32'(state_o), 32'(m_phase));
         check("rnd_cnt", 32'({stall_cnt_o, flush_cnt_o}), 32'({4'(m_sc), 4'(m_fc)}));
         n_sc = m_sc; n_fc = m_fc;
         case (a)
            A_IDLE:   n_ph = (m_phase == 0 && start_i) ? 1 : 0;
            A_FREEZE: begin n_ph = 2; n_sc = (m_sc < cnt_max) ? m_sc + 1 : m_sc; end
            A_HOLD:   begin n_ph = 1; n_sc = (m_sc < cnt_max) ? m_sc + 1 : m_sc; end
            A_BRANCH: begin n_ph = 1; n_fc = (m_fc < cnt_max) ? m_fc + 1 : m_fc; end
            default:  n_ph = 1;
         endcase
         @(posedge clk_i);
         if (rst_i) begin
            m_phase = n_ph; m_sc = n_sc; m_fc = n_fc;
         end
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Sequencing controller for the program counter and IF/ID register in the pipelined CPU. Each cycle it decides among advance (PC+4), redirect (taken branch), hold (load-use hazard) and freeze (data-memory stall), and drives the PC write/stall controls and the IF/ID write/flush controls. A small FSM tracks the idle, running and memory-wait phases. Saturating counters record stall and flush events for debug.

## Interface
- CNT_W, 16, width of the saturating event counters
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; asynchronous, active-low
- start_i  in  1  run enable; low holds the core idle
- dmem_stall_i  in  1  data memory busy; the whole pipeline must freeze
- EX_memread_i  in  1  instruction in EX is a load
- EX_rt_i  in  5  destination register of the load in EX
- ID_rs_i  in  5  rs field of the instruction in ID
- ID_rt_i  in  5  rt field of the instruction in ID
- branch_taken_i  in  1  ID stage resolved a taken branch or jump
- branch_target_i  in  32  redirect address
- PC_plus4_i  in  32  sequential next address
- PC_next_o  out  32  next-PC value to the PC register
- PC_write_o  out  1  PC register loads PC_next_o
- PC_stall_o  out  1  PC register holds unconditionally
- IFID_write_o  out  1  IF/ID register loads
- IFID_flush_o  out  1  IF/ID register loads a NOP
- ID_bubble_o  out  1  zero the control signals entering ID/EX
- pipe_freeze_o  out  1  freeze all pipeline registers (memory stall)
- state_o  out  2  FSM state: 00 IDLE, 01 RUN, 10 MEM_WAIT
- stall_cnt_o  out  CNT_W  cycles in which the PC did not advance while in RUN or MEM_WAIT
- flush_cnt_o  out  CNT_W  number of branch redirects taken

## Operation
- The FSM state and both counters are registers. All other outputs are combinational from the state and the current inputs.
- Hazard definition: hz = EX_memread_i & (EX_rt_i != 0) & ((EX_rt_i == ID_rs_i) | (EX_rt_i == ID_rt_i)).
- IDLE:
  - Outputs: PC_write_o=0, PC_stall_o=0 (the PC register clears to 0 because start_i is low), IFID_write_o=0, IFID_flush_o=1, ID_bubble_o=1, pipe_freeze_o=0.
  - Transition: go to RUN when start_i=1.
- RUN and MEM_WAIT use the same priority order, highest first:
  1. start_i=0: apply the IDLE outputs this cycle; next state is IDLE.
  2. dmem_stall_i=1: PC_stall_o=1, pipe_freeze_o=1, PC_write_o=0, IFID_write_o=0, flush=0, bubble=0; next state is MEM_WAIT.
  3. hz=1: PC_write_o=0, PC_stall_o=0, IFID_write_o=0, ID_bubble_o=1; next state is RUN.
  4. branch_taken_i=1: PC_write_o=1, PC_next_o=branch_target_i, IFID_write_o=1, IFID_flush_o=1; next state is RUN.
  5. Otherwise: PC_write_o=1, PC_next_o=PC_plus4_i, IFID_write_o=1, flush=0, bubble=0; next state is RUN.
- PC_next_o equals PC_plus4_i whenever case 4 is not selected.
- Load-use hazard and branch in the same cycle: the hazard wins. The branch is re-evaluated the following cycle with forwarded data and is not counted in this cycle.
- Branch during a memory stall: the branch is not applied. ID is frozen, so branch_taken_i stays asserted and is acted on in the first cycle dmem_stall_i=0.
- stall_cnt_o: increments by 1 on each clock edge where the state is RUN or MEM_WAIT, start_i=1 and case 2 or case 3 is selected. It saturates at 2^CNT_W-1.
- flush_cnt_o: increments on each case-4 cycle and saturates at 2^CNT_W-1.
- Both counters keep their values across IDLE. Only rst_i clears them.

## Timing
- Reset (rst_i=0, asynchronous): state=IDLE, both counters=0. Outputs immediately take the IDLE values; PC_next_o=PC_plus4_i.
- start_i rising edge: start_i is sampled at edge N, the state is RUN after edge N, and the first PC write occurs at edge N+1. The PC therefore reads 0 for the first fetch.
- Control latency for stall, hazard and branch is zero cycles: outputs respond combinationally in the same cycle. The state change becomes visible after the next edge.
- MEM_WAIT: stays in MEM_WAIT while dmem_stall_i=1. In the first cycle dmem_stall_i=0, the normal priority cases apply and the next state is RUN.
- Reset asserted mid-operation (in RUN or MEM_WAIT): the block returns to IDLE at once and the counters clear. No pending branch is retained.
- start_i=0 during MEM_WAIT: takes priority over the stall; next state is IDLE and pipe_freeze_o=0.

## Test plan
- Reset then start_i=1 with no hazards, PC_plus4_i=4,8,12: state is 00, then 01; PC_write_o=1 from the second cycle; PC_next_o follows PC_plus4_i; both counters stay 0.
- Load-use: EX_memread_i=1, EX_rt_i=5, ID_rs_i=5 for one cycle: PC_write_o=0, IFID_write_o=0, ID_bubble_o=1, stall_cnt_o goes 0 to 1. The same stimulus with EX_rt_i=0 produces no stall.
- Hazard together with branch_taken_i=1 and target 0x40: hazard outputs only in that cycle. In the next cycle (hz=0), PC_next_o=0x40, IFID_flush_o=1, and flush_cnt_o becomes 1.
- dmem_stall_i high for 3 cycles with branch_taken_i=1 and target 0x80: state_o=10 for 3 cycles, PC_stall_o=1 and pipe_freeze_o=1 throughout, stall_cnt_o increases by 3. In the release cycle, PC_next_o=0x80 with PC_write_o=1.
- start_i dropped during MEM_WAIT: next state is 00; PC_stall_o=0 and PC_write_o=0; counters hold their values.
- Saturation with CNT_W=4: 20 consecutive hazard cycles leave stall_cnt_o=15. Asserting rst_i mid-run clears the counter to 0 asynchronously.
